// File: rtl/cic_pkg.sv
// Shared helpers for the CIC PDM decimator: width derivation and PDM bit encodings.
package cic_pkg;

  localparam logic signed [1:0] PDM_POS = 2'sb01;
  localparam logic signed [1:0] PDM_NEG = 2'sb11;

  function automatic int clog2(input int v);
    int r;
    int p;
    r = 0;
    p = 1;
    for (int i = 0; i < 31; i++) begin
      if (p < v) r = i + 1;
      p = p * 2;
    end
    return r;
  endfunction

  function automatic int acc_w(input int n, input int r, input int m);
    return 2 + n * clog2(r * m);
  endfunction

endpackage

// File: rtl/cic_chan.sv
// One CIC lane: N wrapping integrators, N combs with M-deep delays, output scaler.
// Rounding/saturation in the scaler is enabled by CIC_ROUND_SAT_EN.
module cic_chan
  import cic_pkg::*;
#(
  parameter int N     = 2,
  parameter int M     = 1,
  parameter int ACC_W = 12,
  parameter int OUT_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic                    dec,
  input  logic                    din,
  output logic signed [OUT_W-1:0] dout
);

  localparam int SH = ACC_W - OUT_W;

  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] integ   [N];
  logic signed [ACC_W-1:0] dly     [N][M];
  logic signed [ACC_W-1:0] comb_in [N];
  logic signed [ACC_W-1:0] comb_acc;
  logic signed [ACC_W-1:0] comb_out;
  logic signed [OUT_W-1:0] scaled;

  assign x = din ? ACC_W'(PDM_POS) : ACC_W'(PDM_NEG);

  // Comb chain, evaluated from the last integrator's pre-edge value.
  always_comb begin
    comb_acc = integ[N-1];
    for (int k = 0; k < N; k++) begin
      comb_in[k] = comb_acc;
      comb_acc   = comb_acc - dly[k][M-1];
    end
    comb_out = comb_acc;
  end

  generate
    if (SH > 0) begin : g_shift
      logic unused_lsb;
`ifdef CIC_ROUND_SAT_EN
      localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (SH - 1);
      localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
      localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
      logic signed [ACC_W:0] rnd;
      logic signed [OUT_W:0] rsh;
      assign rnd = $signed({comb_out[ACC_W-1], comb_out}) + $signed(HALF);
      assign rsh = rnd[ACC_W:SH];
      assign unused_lsb = ^rnd[SH-1:0];
      // One guard bit above OUT_W exposes overflow of the rounded value.
      assign scaled = (rsh[OUT_W] != rsh[OUT_W-1]) ? (rsh[OUT_W] ? SAT_MIN : SAT_MAX)
                                                   : rsh[OUT_W-1:0];
`else
      assign scaled = comb_out[ACC_W-1:SH];
      assign unused_lsb = ^comb_out[SH-1:0];
`endif
    end else begin : g_extend
      assign scaled = OUT_W'(comb_out);
    end
  endgenerate

  // Integrators, comb delay lines and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        integ[k] <= '0;
        for (int m = 0; m < M; m++) dly[k][m] <= '0;
      end
      dout <= '0;
    end else if (we) begin
      integ[0] <= integ[0] + x;
      for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
      if (dec) begin
        for (int k = 0; k < N; k++) begin
          dly[k][0] <= comb_in[k];
          for (int m = 1; m < M; m++) dly[k][m] <= dly[k][m-1];
        end
        dout <= scaled;
      end
    end
  end

endmodule

// File: rtl/cic_pdm_decim.sv
// Multi-channel Hogenauer CIC decimator for PDM bitstreams; shared decimation counter and valid.
// Optional rounding/saturation of the scaled output: define CIC_ROUND_SAT_EN.
module cic_pdm_decim
  import cic_pkg::*;
#(
  parameter int N     = 2,
  parameter int R     = 32,
  parameter int M     = 1,
  parameter int CH    = 1,
  parameter int OUT_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [CH-1:0]         data_in,
  output logic [CH*OUT_W-1:0]   data_out,
  output logic                  valid
);

  localparam int ACC_W = acc_w(N, R, M);
  localparam int CNT_W = clog2(R);

  logic [CNT_W-1:0] cnt;
  logic             dec;

  assign dec = we && (cnt == CNT_W'(R - 1));

  // Decimation counter; valid strobes in the cycle after an event edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= dec;
      if (we) cnt <= dec ? '0 : cnt + CNT_W'(1);
    end
  end

  generate
    for (genvar c = 0; c < CH; c++) begin : g_chan
      cic_chan #(
        .N     (N),
        .M     (M),
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
      ) u_chan (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .dec  (dec),
        .din  (data_in[c]),
        .dout (data_out[c*OUT_W +: OUT_W])
      );
    end
  endgenerate

endmodule
